// File: rtl/rv_core_pkg.sv
// Shared core definitions: fetch FSM states, IF/ID payload and fetch address checks.
package rv_core_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] instr;
   } if_id_t;

   // Word index of addr lies inside an instruction memory of depth words.
   function automatic logic in_range(input logic [XLEN-1:0] addr, input int unsigned depth);
      return 32'(addr[XLEN-1:2]) < depth;
   endfunction

   // Word aligned and inside the instruction memory.
   function automatic logic fetch_legal(input logic [XLEN-1:0] addr, input int unsigned depth);
      return (addr[1:0] == 2'b00) && in_range(addr, depth);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, flush and consume controls.
module if_id_reg
   import rv_core_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   load,
   input  logic   flush,
   input  logic   consume,
   input  if_id_t entry_in,
   output logic   valid,
   output if_id_t entry
);

   // Flush beats load; consume only empties the slot when nothing new arrives.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid          <= 1'b0;
         entry.pc       <= '0;
         entry.pc_plus4 <= '0;
         entry.instr    <= NOP;
      end else if (flush) begin
         valid       <= 1'b0;
         entry.instr <= NOP;
      end else if (load) begin
         valid <= 1'b1;
         entry <= entry_in;
      end else if (consume) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: program counter, fetch FSM, redirect handling and IF/ID handshake.
module instruction_fetch
   import rv_core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned     IMEM_DEPTH = 1024,
   parameter logic [XLEN-1:0] NOP        = NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] imem_addr,
   output logic            imem_read_en,
   input  logic [XLEN-1:0] imem_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            id_ready,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pc_plus4,
   output logic [XLEN-1:0] if_instr,
   output logic            fetch_fault,
   output logic [XLEN-1:0] fault_addr
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] seq_pc;
   logic            slot_free;
   logic            do_load;
   logic            do_flush;
   logic            do_consume;
   if_id_t          load_entry;
   if_id_t          held_entry;

   assign seq_pc     = pc + 32'd4;
   assign slot_free  = !if_valid || id_ready;
   assign do_flush   = (state != ST_BOOT) && redirect_valid;
   assign do_load    = (state == ST_RUN) && !redirect_valid && slot_free;
   // In RUN a free slot always refills, so only FAULT needs an explicit drain.
   assign do_consume = (state == ST_FAULT) && if_valid && id_ready;
   assign load_entry = '{pc: pc, pc_plus4: seq_pc, instr: imem_data};
   assign imem_addr  = pc;

   // PC, fetch FSM and fault bookkeeping; redirect outranks capture and stall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_BOOT;
         pc           <= RESET_PC;
         imem_read_en <= 1'b0;
         fetch_fault  <= 1'b0;
         fault_addr   <= '0;
      end else begin
         case (state)
            ST_BOOT: begin
               state        <= ST_RUN;
               imem_read_en <= 1'b1;
            end
            ST_RUN, ST_FAULT: begin
               if (redirect_valid) begin
                  pc <= redirect_target;
                  if (fetch_legal(redirect_target, IMEM_DEPTH)) begin
                     state        <= ST_RUN;
                     imem_read_en <= 1'b1;
                     fetch_fault  <= 1'b0;
                  end else begin
                     state        <= ST_FAULT;
                     imem_read_en <= 1'b0;
                     fetch_fault  <= 1'b1;
                     fault_addr   <= redirect_target;
                  end
               end else if (state == ST_RUN && slot_free) begin
                  pc <= seq_pc;
                  if (!in_range(seq_pc, IMEM_DEPTH)) begin
                     state        <= ST_FAULT;
                     imem_read_en <= 1'b0;
                     fetch_fault  <= 1'b1;
                     fault_addr   <= seq_pc;
                  end
               end
            end
            default: begin
               state        <= ST_BOOT;
               imem_read_en <= 1'b0;
            end
         endcase
      end
   end

   if_id_reg #(
      .NOP (NOP)
   ) u_if_id (
      .clk      (clk),
      .reset    (reset),
      .load     (do_load),
      .flush    (do_flush),
      .consume  (do_consume),
      .entry_in (load_entry),
      .valid    (if_valid),
      .entry    (held_entry)
   );

   assign if_pc       = held_entry.pc;
   assign if_pc_plus4 = held_entry.pc_plus4;
   assign if_instr    = held_entry.instr;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
IF stage front end: owns the program counter and drives the word-addressed instruction memory. The memory has a combinational read and returns NOP (0x00000013) when its read is disabled or the address is out of range. This block registers each fetched word into the IF/ID pipeline register and offers it to decode over a valid/ready handshake. It also handles branch/jump redirects from later stages and flags misaligned or out-of-range fetch targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_DEPTH, 1024, instruction memory size in 32-bit words; used for range check
NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_addr  output  32  byte address to instruction memory; always equals pc
imem_read_en  output  1  memory read enable
imem_data  input  32  combinational read data from memory
redirect_valid  input  1  taken branch/jump/trap from a later stage
redirect_target  input  32  new PC when redirect_valid=1
id_ready  input  1  decode can accept the IF/ID entry this cycle
if_valid  output  1  IF/ID entry valid
if_pc  output  32  PC of the held instruction
if_pc_plus4  output  32  if_pc + 4, modulo 2^32
if_instr  output  32  held instruction word
fetch_fault  output  1  FSM is in FAULT
fault_addr  output  32  offending address, latched on fault entry

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, state=BOOT, if_valid=0, if_instr=NOP, if_pc=0, if_pc_plus4=0, fetch_fault=0, fault_addr=0.
- FSM states BOOT, RUN, FAULT. imem_read_en=1 only in RUN. imem_addr=pc in every state.
- BOOT: lasts exactly one cycle after reset is released. No capture happens. Next state is RUN.
- RUN, capture condition is slot_free = !if_valid || id_ready. On every edge with slot_free and no redirect:
  - if_instr<=imem_data, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1, pc<=pc+4.
  - Throughput is one instruction per cycle. Latency from address to if_instr is one edge.
- Stall (if_valid=1, id_ready=0): all IF/ID outputs and pc hold. imem_addr stays stable.
- Handshake: a transfer occurs on an edge where if_valid=1 and id_ready=1. A new word may be captured on that same edge (no bubble).
- Redirect has priority over capture and over stall, and applies in any state except BOOT:
  - pc<=redirect_target, if_valid<=0, if_instr<=NOP. The held entry is flushed even if id_ready=0.
  - If redirect_target[1:0]!=0 or redirect_target[31:2]>=IMEM_DEPTH: state<=FAULT, fault_addr<=redirect_target.
  - Otherwise: state<=RUN, fetch_fault clears.
- Sequential overflow: in RUN, if pc+4 yields a word index >=IMEM_DEPTH, the capture still occurs. On that edge state<=FAULT and fault_addr<=pc+4. pc still updates.
- FAULT: no captures and imem_read_en=0. A held valid entry stays until decode consumes it, then if_valid=0. Only a legal redirect leaves FAULT.
- PC arithmetic is 32-bit and wraps modulo 2^32. pc[1:0] is always 00 outside a fault.
- Reset asserted mid-operation clears everything immediately; no partial state survives.

Decomposition:
- Shared package rv_core_pkg: NOP constant, fetch FSM state enum (BOOT/RUN/FAULT), XLEN=32.
- One sub-module: if_id_reg holds the pipeline register with hold/flush/load controls. The PC and FSM stay in instruction_fetch.

Test Plan:
- Reset release with RESET_PC=0, memory words 0..3 = A,B,C,D, id_ready=1: BOOT for 1 cycle. Then if_instr=A,B,C,D on consecutive cycles with if_pc=0,4,8,C and if_pc_plus4=4,8,C,10.
- Stall: id_ready=0 for 3 cycles while holding B: if_instr=B and if_pc=4 stable, imem_addr=8 stable. After id_ready=1, C follows with no loss or duplicate.
- Redirect while stalled: if_valid=1, id_ready=0, redirect_target=0x40: next cycle if_valid=0 and if_instr=NOP. The following cycle delivers word 16 with if_pc=0x40.
- Misaligned redirect to 0x42: fetch_fault=1, fault_addr=0x42, imem_read_en=0, if_valid stays 0. A subsequent redirect to 0x80 returns to RUN with fault cleared.
- End of memory with IMEM_DEPTH=4: word at 0xC is delivered, then fetch_fault=1 with fault_addr=0x10, and no further captures occur.
- Asynchronous reset pulse mid-stream, between clock edges: outputs return to their reset values immediately. Fetch restarts at RESET_PC after BOOT.
